// File: rtl/ws2812_driver.sv
`timescale 1ns/1ps
// ws2812_driver: single-wire NRZ serial output for a chain of WS2812-style LEDs, all showing one colour.
// Latency: outputs are registered decodes of the FSM state, so dout first rises 2 cycles after enable is seen in IDLE.
// Backpressure: none; enable is only sampled in IDLE, and a started frame always runs through LATCH.
// Optional macro WS2812_REFRESH_ON_CHANGE_EN: only start a frame when the colour differs from the last frame sent.
module ws2812_driver #(
   parameter int T0H      = 4,
   parameter int T1H      = 8,
   parameter int T_BIT    = 15,
   parameter int T_RESET  = 960,
   parameter int NUM_LEDS = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] level_r,
   input  logic [7:0] level_g,
   input  logic [7:0] level_b,
   input  logic       enable,
   output logic       dout,
   output logic       busy,
   output logic       frame_done
);

   // One timing counter serves both the bit phases and the latch period.
   localparam int TMAX = (T_RESET > T_BIT) ? T_RESET : T_BIT;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam int LW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

   localparam logic [TW-1:0] HI0_LAST = TW'(T0H - 1);
   localparam logic [TW-1:0] HI1_LAST = TW'(T1H - 1);
   localparam logic [TW-1:0] LO0_LAST = TW'(T_BIT - T0H - 1);
   localparam logic [TW-1:0] LO1_LAST = TW'(T_BIT - T1H - 1);
   localparam logic [TW-1:0] LAT_LAST = TW'(T_RESET - 1);
   localparam logic [LW-1:0] LED_LAST = LW'(NUM_LEDS - 1);

   generate
      if (!(T0H > 0 && T0H < T1H && T1H < T_BIT && T_RESET >= 1 && NUM_LEDS >= 1)) begin : g_bad_params
         $error("ws2812_driver: illegal timing or chain-length parameters");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      BIT_HIGH,
      BIT_LOW,
      LATCH
   } state_t;

   state_t          state;
   logic [23:0]     shadow;     // bits still to send for the current LED, MSB goes out next
   logic [23:0]     frame_word; // colour snapshot taken at LOAD, reused for every LED
   logic [4:0]      bit_cnt;
   logic [LW-1:0]   led_cnt;
   logic [TW-1:0]   tcnt;
   logic [23:0]     live_word;
   logic            start;

   assign live_word = {level_g, level_r, level_b};

`ifdef WS2812_REFRESH_ON_CHANGE_EN
   logic [23:0] sent_word;
   logic        sent;

   assign start = enable && (!sent || (live_word != sent_word));

   // Remember the colour committed at LOAD so an unchanged colour does not retrigger.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sent_word <= '0;
         sent      <= 1'b0;
      end else if (state == LOAD) begin
         sent_word <= live_word;
         sent      <= 1'b1;
      end
   end
`else
   assign start = enable;
`endif

   // Frame sequencer; outputs are registered from the current state, one cycle behind it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         shadow     <= '0;
         frame_word <= '0;
         bit_cnt    <= '0;
         led_cnt    <= '0;
         tcnt       <= '0;
         dout       <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         dout       <= (state == BIT_HIGH);
         busy       <= (state != IDLE);
         frame_done <= (state == LATCH) && (tcnt == '0);

         case (state)
            IDLE: begin
               if (start) begin
                  state <= LOAD;
               end
            end

            LOAD: begin
               shadow     <= live_word;
               frame_word <= live_word;
               bit_cnt    <= 5'd23;
               led_cnt    <= LED_LAST;
               tcnt       <= live_word[23] ? HI1_LAST : HI0_LAST;
               state      <= BIT_HIGH;
            end

            BIT_HIGH: begin
               if (tcnt == '0) begin
                  tcnt  <= shadow[23] ? LO1_LAST : LO0_LAST;
                  state <= BIT_LOW;
               end else begin
                  tcnt <= tcnt - TW'(1);
               end
            end

            BIT_LOW: begin
               if (tcnt != '0) begin
                  tcnt <= tcnt - TW'(1);
               end else if (bit_cnt != 5'd0) begin
                  // Next bit of the same LED.
                  shadow  <= {shadow[22:0], 1'b0};
                  bit_cnt <= bit_cnt - 5'd1;
                  tcnt    <= shadow[22] ? HI1_LAST : HI0_LAST;
                  state   <= BIT_HIGH;
               end else if (led_cnt != '0) begin
                  // Next LED: replay the snapshot, not the live inputs, with no gap.
                  shadow  <= frame_word;
                  bit_cnt <= 5'd23;
                  led_cnt <= led_cnt - LW'(1);
                  tcnt    <= frame_word[23] ? HI1_LAST : HI0_LAST;
                  state   <= BIT_HIGH;
               end else begin
                  tcnt  <= LAT_LAST;
                  state <= LATCH;
               end
            end

            LATCH: begin
               if (tcnt == '0) begin
                  state <= IDLE;
               end else begin
                  tcnt <= tcnt - TW'(1);
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/ws2812_driver.md
Name: ws2812_driver

Overview:
- Serial LED output stage fed by the three 8-bit encoder level registers (r, g, b), alongside the PWM outputs.
- Drives a chain of WS2812-style addressable LEDs over a single-wire NRZ link, all LEDs showing the same colour.
- Snapshots the colour at frame start, shifts 24 bits per LED in GRB order, MSB first, then holds the line low for the latch period.

Parameters:
- T0H, 4, cycles dout is high for a 0 bit
- T1H, 8, cycles dout is high for a 1 bit
- T_BIT, 15, total cycles per bit (high + low)
- T_RESET, 960, cycles dout is held low after the last bit (latch)
- NUM_LEDS, 1, LEDs in chain; each receives the same 24-bit word

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- level_r  input  8  red level
- level_g  input  8  green level
- level_b  input  8  blue level
- enable  input  1  start/continue frame transmission when high
- dout  output  1  serial data line to first LED
- busy  output  1  high from LOAD through end of LATCH
- frame_done  output  1  one-cycle pulse on the last LATCH cycle

Behaviour:
- Single clock domain. Reset is asynchronous and active-high.
- On reset: dout=0, busy=0, frame_done=0, state=IDLE, all counters and shadow register cleared.
- All outputs are registered.
- States: IDLE, LOAD, BIT_HIGH, BIT_LOW, LATCH.
- IDLE:
  - dout=0, busy=0.
  - enable sampled 1 -> LOAD on the next cycle.
- LOAD (1 cycle):
  - shadow <= {level_g, level_r, level_b}; bit counter=23; LED counter=NUM_LEDS-1.
  - busy=1, dout=0.
  - Next state: BIT_HIGH.
- BIT_HIGH:
  - dout=1 for T1H cycles if shadow[23]=1, else T0H cycles.
  - Next state: BIT_LOW.
- BIT_LOW:
  - dout=0 for T_BIT-T1H or T_BIT-T0H cycles, so every bit is exactly T_BIT cycles.
  - On its last cycle:
    - bits remain -> shift left, go to BIT_HIGH;
    - else LEDs remain -> reload shadow from the LOAD snapshot (not the live inputs), go to BIT_HIGH;
    - else -> LATCH.
  - LED boundaries add no gap cycles.
- LATCH:
  - dout=0 for T_RESET cycles; frame_done=1 on the final cycle only.
  - Next state: IDLE.
- Latency:
  - dout first rises 2 cycles after enable is sampled high in IDLE.
  - LOAD to IDLE takes 1 + NUM_LEDS*24*T_BIT + T_RESET cycles.
  - With enable held high, frames repeat with 1 IDLE cycle between them.
- Input changes: level_* changes after LOAD do not affect the frame in flight.
- enable deasserted mid-frame: the current frame completes, including LATCH, then the block stays in IDLE.
- Reset mid-frame: dout drops to 0 asynchronously; no frame_done; the next frame starts from LOAD.
- Constraints: 0 < T0H < T1H < T_BIT, T_RESET >= 1, NUM_LEDS >= 1. Violations are an elaboration error.
- Counter widths sized from the parameters with $clog2.

Optional Feature:
- Macro: WS2812_REFRESH_ON_CHANGE_EN.
- Defined:
  - The block keeps the last transmitted 24-bit word and a "sent" flag, both cleared by reset.
  - In IDLE, enable starts a frame only if the flag is clear or {level_g, level_r, level_b} differs from the stored word.
  - The stored word updates at LOAD.
- Undefined:
  - No extra state; frames repeat continuously while enable=1.

Test Plan:
- Reset held 5 cycles, then released with enable=0 -> dout=0, busy=0, frame_done=0 for 100 cycles.
- r=0xFF, g=0x00, b=0x0F, enable pulsed 1 cycle, defaults:
  - 8 high pulses of 4 cycles (g), then 8 of 8 cycles (r), then 4 of 4 and 4 of 8 (b), each bit period 15 cycles;
  - 960 low cycles follow; frame_done pulses once, 1321 cycles after LOAD entry; busy falls next cycle.
- Same stimulus, but level_r changed to 0x00 at cycle 50 of the frame -> waveform identical to the previous case.
- NUM_LEDS=3, g=0xA5, r=0x00, b=0x00 -> 72 bits, pattern repeated 3 times with no gap; frame_done 1+1080+960 cycles after LOAD.
- Reset asserted during a BIT_HIGH of a 1 bit -> dout=0 immediately, busy=0, no frame_done; after release with enable=1, a fresh frame starts from bit 23.
- With WS2812_REFRESH_ON_CHANGE_EN, enable held 1, inputs constant -> exactly one frame. Then change b by 1 -> exactly one more frame. Without the macro -> back-to-back frames.
